// File: rtl/delay_line.sv
// Fixed-latency delay line: every input sample reappears on out exactly DELAY clock cycles later.
// DELAY=0 degenerates to a combinational wire; otherwise out is the last register of the chain.
module delay_line #(
    parameter int               DELAY       = 5,
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    generate
        if (DELAY < 0 || WIDTH < 1) begin : g_bad_params
            $error("delay_line: DELAY must be >= 0 and WIDTH must be >= 1");
        end else if (DELAY == 0) begin : g_passthrough
            // No state here, so clock and reset have nothing to act on.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign out            = in;
        end else begin : g_stages
            // Stage 0 captures in; stage DELAY-1 drives out. Power-up value matches reset.
            logic [WIDTH-1:0] stage_q [DELAY] = '{default: RESET_VALUE};
            logic [WIDTH-1:0] stage_d [DELAY];

            always_comb begin
                stage_d[0] = in;
                for (int i = 1; i < DELAY; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DELAY; i++) begin
                        stage_q[i] <= RESET_VALUE;
                    end
                end else begin
                    for (int i = 0; i < DELAY; i++) begin
                        stage_q[i] <= stage_d[i];
                    end
                end
            end

            assign out = stage_q[DELAY-1];
        end
    endgenerate

endmodule

// File: tb/tb_delay_line.sv
// Bench for delay_line: four instances (DELAY 5/3/1/0) share one clock and reset.
// A table drives the hand-derived DELAY=5 scenarios; a per-edge scoreboard checks every instance.
`timescale 1ns/1ps
module tb_delay_line;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #41.667 clk = ~clk;

    logic       rst  = 1'b0;
    logic       in_a = 1'b0;
    logic [7:0] in_b = 8'h00;
    logic [7:0] in_c = 8'h00;
    logic [7:0] in_d = 8'h00;
    logic       out_a;
    logic [7:0] out_b;
    logic [7:0] out_c;
    logic [7:0] out_d;

    localparam int         DA  = 5;
    localparam int         DB  = 3;
    localparam int         DD  = 1;
    localparam logic [7:0] RVB = 8'hA5;
    localparam logic [7:0] RVD = 8'h3C;

    delay_line #(.DELAY(DA), .WIDTH(1), .RESET_VALUE(1'b0)) u_a (
        .clk(clk), .rst(rst), .in(in_a), .out(out_a));
    delay_line #(.DELAY(DB), .WIDTH(8), .RESET_VALUE(RVB)) u_b (
        .clk(clk), .rst(rst), .in(in_b), .out(out_b));
    delay_line #(.DELAY(0), .WIDTH(8), .RESET_VALUE(8'h00)) u_c (
        .clk(clk), .rst(rst), .in(in_c), .out(out_c));
    delay_line #(.DELAY(DD), .WIDTH(8), .RESET_VALUE(RVD)) u_d (
        .clk(clk), .rst(rst), .in(in_d), .out(out_d));

    int errors = 0;
    int checks = 0;
    bit done   = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    // Each queue holds DELAY-1 samples in flight; one is pushed and one popped per edge.
    logic [7:0] exp_a_q[$];
    logic [7:0] exp_b_q[$];
    logic [7:0] exp_d_q[$];

    initial begin
        logic       s_rst;
        logic [7:0] s_a, s_b, s_c, s_d;
        logic [7:0] e_a, e_b, e_d;
        for (int i = 0; i < DA - 1; i++) exp_a_q.push_back(8'h00);
        for (int i = 0; i < DB - 1; i++) exp_b_q.push_back(RVB);
        for (int i = 0; i < DD - 1; i++) exp_d_q.push_back(RVD);
        #1;
        check("powerup_a", {7'd0, out_a}, 8'h00);
        check("powerup_b", out_b, RVB);
        check("powerup_d", out_d, RVD);
        while (!done) begin
            @(posedge clk);
            s_rst = rst;
            s_a   = {7'd0, in_a};
            s_b   = in_b;
            s_c   = in_c;
            s_d   = in_d;
            if (s_rst) begin
                exp_a_q.delete();
                exp_b_q.delete();
                exp_d_q.delete();
                for (int i = 0; i < DA - 1; i++) exp_a_q.push_back(8'h00);
                for (int i = 0; i < DB - 1; i++) exp_b_q.push_back(RVB);
                for (int i = 0; i < DD - 1; i++) exp_d_q.push_back(RVD);
                e_a = 8'h00;
                e_b = RVB;
                e_d = RVD;
            end else begin
                exp_a_q.push_back(s_a);
                exp_b_q.push_back(s_b);
                exp_d_q.push_back(s_d);
                e_a = exp_a_q.pop_front();
                e_b = exp_b_q.pop_front();
                e_d = exp_d_q.pop_front();
            end
            #1;
            check("sb_a", {7'd0, out_a}, e_a);
            check("sb_b", out_b, e_b);
            check("sb_c", out_c, s_c);
            check("sb_d", out_d, e_d);
        end
    end

    // ---------------- vector table (DELAY=5, WIDTH=1) ----------------
    // Vector k is driven before edge k; exp_a is out_a just after edge k.
    typedef struct {
        logic rst;
        logic in_a;
        logic exp_a;
    } vec_t;

    localparam int NV = 34;
    vec_t vecs[NV];

    logic [7:0] cnt = 8'h00;

    task automatic drive_side(input logic r);
        if (r) begin
            cnt  = 8'h00;
            in_b = 8'h00;
        end else begin
            in_b = cnt;
            cnt  = cnt + 8'd1;
        end
        in_c = 8'($urandom);
        in_d = 8'($urandom);
        #1;
        check("comb_c", out_c, in_c);
    endtask

    initial begin
        for (int k = 0; k < NV; k++) vecs[k] = '{rst: 1'b0, in_a: 1'b0, exp_a: 1'b0};
        // Reset with in held high: two reset edges, then 1 emerges four edges after release.
        for (int k = 0; k < 8; k++) vecs[k].in_a = 1'b1;
        vecs[0].rst = 1'b1;
        vecs[1].rst = 1'b1;
        vecs[6].exp_a = 1'b1;
        vecs[7].exp_a = 1'b1;
        for (int k = 8; k < 12; k++) vecs[k].exp_a = 1'b1;
        // Pattern 1,0,1,1,0 with reset landing on its fourth sample: nothing may emerge.
        vecs[13].in_a = 1'b1;
        vecs[15].in_a = 1'b1;
        vecs[16].in_a = 1'b1;
        vecs[16].rst  = 1'b1;
        // Single-cycle pulse: seen on out exactly once, four edges later.
        vecs[25].in_a  = 1'b1;
        vecs[29].exp_a = 1'b1;

        // Run a few edges before any reset so power-up contents flow through.
        repeat (3) begin
            @(negedge clk);
            rst  = 1'b0;
            in_a = 1'b0;
            drive_side(1'b0);
        end

        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            rst  = vecs[k].rst;
            in_a = vecs[k].in_a;
            drive_side(vecs[k].rst);
            @(posedge clk);
            #2;
            check($sformatf("tbl_a[%0d]", k), {7'd0, out_a}, {7'd0, vecs[k].exp_a});
        end

        // Hand sequence: slow asynchronous toggle on in_a, period 2000 ns.
        @(negedge clk);
        rst = 1'b0;
        fork
            begin
                repeat (12) begin
                    #1000;
                    in_a = ~in_a;
                end
            end
            begin
                repeat (150) begin
                    @(negedge clk);
                    drive_side(1'b0);
                end
            end
        join

        // Hand sequence: held reset keeps every clocked output at its reset value.
        @(negedge clk);
        rst = 1'b1;
        in_a = 1'b1;
        drive_side(1'b1);
        repeat (3) begin
            @(posedge clk);
            #2;
            check("hold_rst_a", {7'd0, out_a}, 8'h00);
            check("hold_rst_b", out_b, RVB);
            check("hold_rst_d", out_d, RVD);
            @(negedge clk);
            drive_side(1'b1);
        end

        // Random traffic with sporadic resets.
        repeat (400) begin
            @(negedge clk);
            rst  = ($urandom_range(0, 19) == 0);
            in_a = 1'($urandom_range(0, 1));
            drive_side(rst);
        end

        // Combinational path checked between clock edges as well.
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #7;
            in_c = 8'($urandom);
            #1;
            check("mid_cycle_c", out_c, in_c);
        end

        done = 1'b1;
        @(posedge clk);
        #5;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
